fir_result_regfile: RTL and testbench
=====================================

// Module: fir_result_regfile
// PURPOSE
//  Responder side of the regAddr/regData result-readout interface of the FIR top level.
//  Captures a fixed-length block of filter output samples from the datapath stream.
//  Raises done when the block is complete, then serves any stored sample by address
//  so a host or bench can walk regAddr.
//  Sits between the FIR output stage and the top-level readout ports.
// PARAMETERS
//  DATA_W  16  width of one filter output sample (signed, two's complement)
//  DEPTH   64  samples per captured block; power of two, 2..1024
//  AW      $clog2(DEPTH)  internal write-pointer / memory index width
// PORTS
//  clk       in   1       rising-edge clock
//  reset     in   1       asynchronous, active-high reset
//  in_valid  in   1       output sample from FIR datapath is valid
//  in_data   in   DATA_W  signed output sample
//  in_ready  out  1       block accepts a sample this cycle
//  restart   in   1       one-cycle pulse: discard block, begin new capture
//  regAddr   in   32      readout word address
//  regData   out  32      readout data, sign-extended sample
//  done      out  1       DEPTH samples captured, block frozen
//  count     out  AW+1    samples captured in current block (0..DEPTH)
// BEHAVIOUR
//  - Reset (async, active-high) values:
//    - state=CAPTURE, count=0, done=0, in_ready=1.
//    - Memory contents are not reset; unwritten words read undefined.
//  - FSM has two states, CAPTURE and DONE:
//    - CAPTURE: in_ready=1, done=0.
//    - A transfer is in_valid&in_ready at posedge: writes mem[count], count+=1.
//    - The write that makes count==DEPTH moves to DONE on the same edge.
//    - DONE: in_ready=0, done=1. count holds DEPTH. Samples offered are ignored (backpressured).
//  - restart:
//    - Any state, restart=1 at posedge -> CAPTURE, count=0, done=0.
//    - restart has priority: a transfer in the same cycle is dropped and not written.
//  - Readout (combinational, 0-cycle latency):
//    - regData = sign_extend(mem[regAddr[AW-1:0]]) when regAddr < DEPTH, else 32'h0.
//    - Reads are legal in any state. A write and a read to the same address in one cycle
//      return the old word until the edge, the new word after it.
//  - done is registered and changes only on clk or reset.
//  - A reader may advance regAddr every cycle while done=1.
//  - Reset asserted mid-capture: count=0 at once. The partial block is abandoned;
//    stale memory words are not guaranteed.
//  - DATA_W > 32 is illegal (elaboration error). DATA_W == 32 means no extension.
// CONFIGURATION
//  - FIR_RESULT_STATUS_EN defined:
//    - regAddr == DEPTH reads the status word {done, 15'b0, 16'(count)}.
//    - Any regAddr > DEPTH reads 0.
//  - FIR_RESULT_STATUS_EN undefined: every regAddr >= DEPTH reads 0, no status word.
// STRUCTURE
//  - Package fir_pkg holds:
//    - FIR_DATA_W and FIR_RESULT_DEPTH constants.
//    - typedef enum logic {CAPTURE, DONE} fir_res_state_t.
//    - typedef logic signed [FIR_DATA_W-1:0] fir_sample_t.
//  - Sub-module fir_result_mem: DEPTH x DATA_W memory, one synchronous write port,
//    one asynchronous read port.
//  - The top module holds the FSM, count, address decode and sign extension.
// TESTING
//  1. Reset, then stream 64 samples 0,1,..,63 (DEPTH=64):
//     done rises on the edge of the 64th write; in_ready=0; count=64.
//  2. After 1, sweep regAddr 0..63 one per cycle: regData == regAddr each cycle;
//     regAddr=64 reads 0 (status word 32'h8000_0040 if FIR_RESULT_STATUS_EN).
//  3. Negative sample 16'hFFF6 written at address 5 -> regData = 32'hFFFF_FFF6.
//  4. Hold in_valid=1 in DONE with new data 16'h1234 for 10 cycles:
//     memory unchanged, count stays 64.
//  5. restart together with in_valid at count=10:
//     count=0 next cycle, sample not written, done=0, in_ready=1.
//  6. Assert reset at count=30 mid-stream: done=0, count=0 immediately (asynchronous).
//     After release, a full 64-sample capture completes normally.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants and types for the FIR result readout block.
package fir_pkg;

  localparam int FIR_DATA_W       = 16;
  localparam int FIR_RESULT_DEPTH = 64;

  typedef enum logic {CAPTURE, DONE} fir_res_state_t;

  typedef logic signed [FIR_DATA_W-1:0] fir_sample_t;

endpackage

// File: rtl/fir_result_mem.sv
// Sample store for one captured block: DEPTH x DATA_W, one synchronous write
// port and one asynchronous read port. Contents are never reset.
module fir_result_mem
  import fir_pkg::*;
#(
  parameter int DATA_W = FIR_DATA_W,
  parameter int DEPTH  = FIR_RESULT_DEPTH,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [AW-1:0]            waddr_i,
  input  logic signed [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]            raddr_i,
  output logic signed [DATA_W-1:0] rdata_o
);

  logic signed [DATA_W-1:0] mem_q [DEPTH];

  // Write port: one sample per enabled clock edge.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read port is combinational, so a same-cycle write is seen only after the edge.
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fir_result_regfile.sv
// Result readout register file for the FIR top level.
// Captures a block of DEPTH output samples, then freezes and raises done; any
// stored sample can be read by word address as a sign-extended 32-bit value.
// Optional build macro FIR_RESULT_STATUS_EN: address DEPTH returns the status
// word {done, 15'b0, count}. Without it, every address >= DEPTH reads zero.
module fir_result_regfile
  import fir_pkg::*;
#(
  parameter int DATA_W = FIR_DATA_W,
  parameter int DEPTH  = FIR_RESULT_DEPTH,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     in_ready,
  input  logic                     restart,
  input  logic [31:0]              regAddr,
  output logic [31:0]              regData,
  output logic                     done,
  output logic [AW:0]              count
);

  // Elaboration-time parameter guards.
  if (DATA_W > 32 || DATA_W < 1) begin : g_bad_data_w
    $error("fir_result_regfile: DATA_W must be in 1..32");
  end
  if (DEPTH < 2 || DEPTH > 1024 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fir_result_regfile: DEPTH must be a power of two in 2..1024");
  end

  localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0] CNT_LAST = (AW+1)'(DEPTH - 1);

  fir_res_state_t state_q, state_d;
  logic [AW:0]    count_q, count_d;
  logic           done_q, done_d;
  logic           ready_q, ready_d;

  logic                     wr_en;
  logic [AW-1:0]            wr_addr;
  logic signed [DATA_W-1:0] rd_word;
  logic [31:0]              rd_data;

  // Sign-extend one stored sample to the 32-bit readout word.
  function automatic logic [31:0] sext(input logic signed [DATA_W-1:0] s);
    logic signed [31:0] w;
    w = 32'(s);
    return w;
  endfunction

  // Next-state logic: restart overrides everything, otherwise count accepted samples.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = done_q;
    ready_d = ready_q;
    if (restart) begin
      state_d = CAPTURE;
      count_d = '0;
      done_d  = 1'b0;
      ready_d = 1'b1;
    end else begin
      case (state_q)
        CAPTURE: begin
          if (in_valid) begin
            count_d = count_q + CNT_ONE;
            if (count_q == CNT_LAST) begin
              state_d = DONE;
              done_d  = 1'b1;
              ready_d = 1'b0;
            end
          end
        end
        DONE: begin
          // Block frozen; offered samples are backpressured.
        end
        default: begin
          state_d = CAPTURE;
          count_d = '0;
          done_d  = 1'b0;
          ready_d = 1'b1;
        end
      endcase
    end
  end

  // FSM state and its registered outputs, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CAPTURE;
      count_q <= '0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  // A restart in the same cycle drops the offered sample.
  assign wr_en   = in_valid & ready_q & ~restart & (state_q == CAPTURE);
  assign wr_addr = count_q[AW-1:0];

  fir_result_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (wr_en),
    .waddr_i (wr_addr),
    .wdata_i (in_data),
    .raddr_i (regAddr[AW-1:0]),
    .rdata_o (rd_word)
  );

  // Address decode: samples below DEPTH, optional status word at DEPTH, zero above.
  always_comb begin
    rd_data = '0;
    if (regAddr < 32'(DEPTH)) begin
      rd_data = sext(rd_word);
    end
`ifdef FIR_RESULT_STATUS_EN
    else if (regAddr == 32'(DEPTH)) begin
      rd_data = {done_q, 15'b0, 16'(count_q)};
    end
`endif
  end

  assign regData  = rd_data;
  assign done     = done_q;
  assign in_ready = ready_q;
  assign count    = count_q;

endmodule

// File: tb/tb_fir_result_regfile.sv
// Directed bench for fir_result_regfile (DATA_W=16, DEPTH=64).
module tb_fir_result_regfile;

  localparam int DATA_W = 16;
  localparam int DEPTH  = 64;
  localparam int AW     = 6;

`ifdef FIR_RESULT_STATUS_EN
  localparam logic [31:0] STATUS_FULL = 32'h8000_0040;
`else
  localparam logic [31:0] STATUS_FULL = 32'h0000_0000;
`endif

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     in_ready;
  logic                     restart;
  logic [31:0]              regAddr;
  logic [31:0]              regData;
  logic                     done;
  logic [AW:0]              count;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp;
  } rd_vec_t;

  rd_vec_t rvec[8];

  always #5 clk = ~clk;

  fir_result_regfile #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .restart  (restart),
    .regAddr  (regAddr),
    .regData  (regData),
    .done     (done),
    .count    (count)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] v);
    in_valid = 1'b1;
    in_data  = v;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rvec[0] = '{32'd0,          32'd0};
    rvec[1] = '{32'd5,          32'd5};
    rvec[2] = '{32'd63,         32'd63};
    rvec[3] = '{32'd64,         STATUS_FULL};
    rvec[4] = '{32'd65,         32'd0};
    rvec[5] = '{32'h0000_0100,  32'd0};
    rvec[6] = '{32'h0000_0045,  32'd0};
    rvec[7] = '{32'hFFFF_FFFF,  32'd0};

    reset = 1'b1; in_valid = 1'b0; in_data = '0; restart = 1'b0; regAddr = '0;
    #3;
    check("reset_count", 32'(count), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_ready", 32'(in_ready), 32'd1);
    step();
    reset = 1'b0;

    // Full block of 0..63.
    for (int i = 0; i < DEPTH; i++) begin
      push(16'(i));
      if (i == DEPTH - 2) begin
        check("done_before_last", 32'(done), 32'd0);
        check("count_63", 32'(count), 32'd63);
      end
    end
    check("done_after_64", 32'(done), 32'd1);
    check("ready_after_64", 32'(in_ready), 32'd0);
    check("count_64", 32'(count), 32'd64);

    // Sweep one address per cycle.
    for (int a = 0; a < DEPTH; a++) begin
      regAddr = 32'(a);
      #1;
      check($sformatf("sweep_%0d", a), regData, 32'(a));
      step();
    end

    // Address decode table.
    for (int k = 0; k < 8; k++) begin
      regAddr = rvec[k].addr;
      #1;
      check($sformatf("decode_%h", rvec[k].addr), regData, rvec[k].exp);
    end

    // Offer samples while frozen.
    in_valid = 1'b1; in_data = 16'h1234;
    for (int c = 0; c < 10; c++) begin
      step();
      check("done_hold_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    check("done_hold_count", 32'(count), 32'd64);
    check("done_hold_done", 32'(done), 32'd1);
    for (int a = 0; a < DEPTH; a += 9) begin
      regAddr = 32'(a);
      #1;
      check($sformatf("frozen_mem_%0d", a), regData, 32'(a));
    end

    // Restart from DONE, write addresses 0..4, then read-during-write at 5.
    restart = 1'b1;
    step();
    restart = 1'b0;
    check("restart_done_count", 32'(count), 32'd0);
    check("restart_done_done", 32'(done), 32'd0);
    check("restart_done_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 5; i++) push(16'(200 + i));
    regAddr = 32'd5;
    in_valid = 1'b1; in_data = 16'hFFF6;
    #1;
    check("rdw_old_word", regData, 32'd5);
    step();
    in_valid = 1'b0;
    check("neg_sample", regData, 32'hFFFF_FFF6);
    push(16'h7FFF);
    regAddr = 32'd6;
    #1;
    check("pos_max_sample", regData, 32'h0000_7FFF);
    regAddr = 32'd0;
    #1;
    check("new_block_addr0", regData, 32'd200);
    for (int i = 7; i < 10; i++) push(16'(i));
    check("count_10", 32'(count), 32'd10);

    // Restart with a simultaneous transfer at count=10.
    regAddr = 32'd10;
    in_valid = 1'b1; in_data = 16'h5555; restart = 1'b1;
    step();
    in_valid = 1'b0; restart = 1'b0;
    check("restart_xfer_count", 32'(count), 32'd0);
    check("restart_xfer_done", 32'(done), 32'd0);
    check("restart_xfer_ready", 32'(in_ready), 32'd1);
    check("restart_xfer_nowrite", regData, 32'd10);

    // Asynchronous reset mid-stream at count=30.
    for (int i = 0; i < 30; i++) push(16'(300 + i));
    check("count_30", 32'(count), 32'd30);
    reset = 1'b1;
    #1;
    check("async_reset_count", 32'(count), 32'd0);
    check("async_reset_done", 32'(done), 32'd0);
    check("async_reset_ready", 32'(in_ready), 32'd1);
    #1;
    reset = 1'b0;
    step();

    // Full recapture with mixed-sign samples.
    for (int i = 0; i < DEPTH; i++) push(16'(i * 3 - 100));
    check("recap_done", 32'(done), 32'd1);
    check("recap_count", 32'(count), 32'd64);
    for (int a = 0; a < DEPTH; a++) begin
      logic signed [15:0] s;
      s = 16'(a * 3 - 100);
      regAddr = 32'(a);
      #1;
      check($sformatf("recap_%0d", a), regData, {{16{s[15]}}, s});
      step();
    end
    regAddr = 32'd64;
    #1;
    check("recap_status", regData, STATUS_FULL);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
